dft_wb_arbiter: RTL

DFT_WB_ARBITER -- requirements
Module: dft_wb_arbiter

---
 rtl/dft_wb_arb_pkg.sv | 28 ++
 rtl/dft_wb_arb_timer.sv | 37 +++
 rtl/dft_wb_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dft_wb_arb_pkg.sv
// Shared definitions for the two-requester Wishbone arbiter in front of the DFT core.
// Contents:
//   arb_state_t      - arbiter states IDLE / OWN / ABORT
//   DEFAULT_TIMEOUT  - default stall-cycle limit before an abort
//   pick_winner()    - round-robin choice between the two requesters
package dft_wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT = 255;

  // When both request, the one not granted last wins. A lone requester
  // always wins, regardless of history.
  function automatic logic pick_winner(input logic [1:0] req, input logic last_grant);
    if (req == 2'b11) begin
      return ~last_grant;
    end else if (req[1]) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/dft_wb_arb_timer.sv
// Stall counter for the arbiter: counts consecutive unacknowledged strobe
// cycles of the current owner and flags when the limit is reached.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   clear  - zero the count (has priority over inc)
//   inc    - count one more stall cycle
//   expire - count equals TIMEOUT-1
module dft_wb_arb_timer
  import dft_wb_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  assign expire = (r_count == CW'(TIMEOUT - 1));

  // Holding at the limit keeps the count in range for the single cycle
  // before the arbiter leaves OWN and the clear takes effect.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (inc && !expire) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/dft_wb_arbiter.sv
// Two-requester Wishbone arbiter sharing one DFT-core slave port.
// Round-robin arbitration in IDLE, ownership held for the whole cyc_i
// window, and a one-cycle ABORT (err + timeout pulse) when the core stalls
// the owner's strobe for TIMEOUT cycles.
// Ports:
//   wb_clk_i, wb_rst_i        - clock, synchronous active-high reset
//   m0_* / m1_*               - requester Wishbone ports (adr/dat/sel/we/cyc/stb in,
//                               dat/ack/err out)
//   s_*                       - shared core port (adr/dat/sel/we/cyc/stb out, dat/ack in)
//   grant_o                   - one-hot owner in OWN/ABORT, 2'b00 in IDLE
//   timeout_o                 - one-cycle pulse while aborting
module dft_wb_arbiter
  import dft_wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  input  logic [3:0]            m0_sel_i,
  input  logic                  m0_we_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  input  logic [3:0]            m1_sel_i,
  input  logic                  m1_we_i,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  output logic [3:0]            s_sel_o,
  output logic                  s_we_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  output logic [1:0]            grant_o,
  output logic                  timeout_o
);

  // Requester inputs gathered by index so the owner mux is a plain select.
  logic [ADDR_WIDTH-1:0] w_adr [2];
  logic [DATA_WIDTH-1:0] w_dat [2];
  logic [3:0]            w_sel [2];
  logic [1:0]            w_we;
  logic [1:0]            w_cyc;
  logic [1:0]            w_stb;

  assign w_adr[0] = m0_adr_i;
  assign w_adr[1] = m1_adr_i;
  assign w_dat[0] = m0_dat_i;
  assign w_dat[1] = m1_dat_i;
  assign w_sel[0] = m0_sel_i;
  assign w_sel[1] = m1_sel_i;
  assign w_we     = {m1_we_i,  m0_we_i};
  assign w_cyc    = {m1_cyc_i, m0_cyc_i};
  assign w_stb    = {m1_stb_i, m0_stb_i};

  arb_state_t r_state;
  arb_state_t w_state_next;
  logic       r_owner;
  logic       r_last_grant;
  logic       w_winner;
  logic       w_expire;
  logic       w_stall_inc;
  logic       w_stall_clr;
  logic       w_drive_bus;
  logic       w_abort_out;
  logic       w_show_grant;
  logic [1:0] w_ack;
  logic [1:0] w_err;

  assign w_winner = pick_winner(w_cyc, r_last_grant);

  // A stall is an owner strobe the core has not yet acknowledged.
  assign w_stall_inc = (r_state == OWN) && w_stb[r_owner] && !s_ack_i;
  assign w_stall_clr = (r_state != OWN) || s_ack_i || !w_stb[r_owner];

  dft_wb_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clear  (w_stall_clr),
    .inc    (w_stall_inc),
    .expire (w_expire)
  );

  // State register; owner and last-grant are captured on the IDLE->OWN edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if ((r_state == IDLE) && (|w_cyc)) begin
        r_owner      <= w_winner;
        r_last_grant <= w_winner;
      end
    end
  end

  // Next state. A late ack at the limit suppresses the abort.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (|w_cyc) w_state_next = OWN;
      end
      OWN: begin
        if (w_expire && !s_ack_i) begin
          w_state_next = ABORT;
        end else if (!w_cyc[r_owner]) begin
          w_state_next = IDLE;
        end
      end
      ABORT:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode. Reset masks everything in the same cycle it is sampled.
  always_comb begin
    w_drive_bus  = 1'b0;
    w_abort_out  = 1'b0;
    w_show_grant = 1'b0;
    if (!wb_rst_i) begin
      case (r_state)
        OWN: begin
          w_drive_bus  = 1'b1;
          w_show_grant = 1'b1;
        end
        ABORT: begin
          w_abort_out  = 1'b1;
          w_show_grant = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Only the owner ever sees ack/err; core acks outside OWN are dropped.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign w_ack[gi]   = w_drive_bus  && (r_owner == 1'(gi)) && s_ack_i;
    assign w_err[gi]   = w_abort_out  && (r_owner == 1'(gi));
    assign grant_o[gi] = w_show_grant && (r_owner == 1'(gi));
  end

  assign s_adr_o   = w_drive_bus ? w_adr[r_owner] : '0;
  assign s_dat_o   = w_drive_bus ? w_dat[r_owner] : '0;
  assign s_sel_o   = w_drive_bus ? w_sel[r_owner] : '0;
  assign s_we_o    = w_drive_bus && w_we[r_owner];
  assign s_cyc_o   = w_drive_bus && w_cyc[r_owner];
  assign s_stb_o   = w_drive_bus && w_stb[r_owner];
  assign timeout_o = w_abort_out;

  assign m0_ack_o = w_ack[0];
  assign m1_ack_o = w_ack[1];
  assign m0_err_o = w_err[0];
  assign m1_err_o = w_err[1];
  assign m0_dat_o = wb_rst_i ? '0 : s_dat_i;
  assign m1_dat_o = wb_rst_i ? '0 : s_dat_i;

endmodule
